// File: rtl/output_process_spi_pkg.sv
// Shared frame geometry, defaults and state encoding for the SPI transmit path.
package output_process_spi_pkg;

  localparam int SPI_FRAME_W   = 19;
  localparam int SPI_ADDR_W    = 3;
  localparam int SPI_DATA_W    = 16;
  localparam int SPI_FIFO_SIZE = 256;

  localparam logic [SPI_ADDR_W-1:0] SPI_3BIT_ADDR = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  function automatic logic [SPI_FRAME_W-1:0] make_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/sync_fifo_spi.sv
// Single-clock show-ahead FIFO: head word is always visible on rdata_o, with a
// registered fill count, full flag and a sticky overflow flag.
module sync_fifo_spi import output_process_spi_pkg::*; #(
  parameter int DEPTH = SPI_FIFO_SIZE,
  parameter int WIDTH = SPI_DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     used_o,
  output logic                       full_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      used_q;
  logic             full_q;
  logic             ovf_q;
  logic             wr_en_s;
  logic             rd_en_s;

  assign wr_en_s = wr_i & ~full_q;
  assign rd_en_s = rd_i & (used_q != '0);

  // Storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_s, rd_en_s})
        2'b10: begin
          used_q <= used_q + 1'b1;
          full_q <= (used_q == (AW+1)'(DEPTH-1));
        end
        2'b01: begin
          used_q <= used_q - 1'b1;
          full_q <= 1'b0;
        end
        default: begin
          used_q <= used_q;
          full_q <= full_q;
        end
      endcase
      if (wr_i && full_q) ovf_q <= 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign used_o  = used_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/output_process_spi.sv
// SPI transmit path: buffers 16-bit words and serialises each as a 19-bit
// {ADDR, data} frame on TX_CLK/TX_DATA/TX_LOAD, gated by the far-end stop line.
module output_process_spi import output_process_spi_pkg::*; #(
  parameter int                     FIFO_DEPTH = SPI_FIFO_SIZE,
  parameter int                     CLK_DIV    = 4,
  parameter logic [SPI_ADDR_W-1:0]  ADDR       = SPI_3BIT_ADDR
) (
  input  logic                          SYS_CLK,
  input  logic                          RST,
  input  logic                          WR_REQ,
  input  logic [SPI_DATA_W-1:0]         DATA,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   USED,
  output logic                          OVF,
  input  logic                          RX_STOP,
  output logic                          TX_CLK,
  output logic                          TX_DATA,
  output logic                          TX_LOAD,
  output logic                          BUSY
);

  localparam int DIV_W = $clog2(CLK_DIV);

  tx_state_e              state_q;
  logic [DIV_W-1:0]       div_q;
  logic [4:0]             bit_cnt_q;
  logic [SPI_FRAME_W-2:0] shreg_q;
  logic                   ph_q;
  logic                   lead_q;
  logic                   tx_clk_q, tx_data_q, tx_load_q, busy_q;
  logic                   stop_meta_q, stop_s_q;
  logic [SPI_DATA_W-1:0]  head_s;
  logic [SPI_FRAME_W-1:0] frame_d;
  logic                   pop_s;
  logic                   tick_s;

  sync_fifo_spi #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_DATA_W)) u_fifo (
    .clk_i   (SYS_CLK),
    .rst_ni  (RST),
    .wr_i    (WR_REQ),
    .wdata_i (DATA),
    .rd_i    (pop_s),
    .rdata_o (head_s),
    .used_o  (USED),
    .full_o  (FULL),
    .ovf_o   (OVF)
  );

  assign frame_d = make_frame(ADDR, head_s);
  assign pop_s   = (state_q == ST_IDLE) && (USED != '0) && !stop_s_q;
  assign tick_s  = (div_q == DIV_W'(CLK_DIV-1));

  // Two-flop synchroniser for the far-end stop request.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      stop_meta_q <= 1'b0;
      stop_s_q    <= 1'b0;
    end else begin
      stop_meta_q <= RX_STOP;
      stop_s_q    <= stop_meta_q;
    end
  end

  // Serialiser FSM. Each frame opens with one clockless TX_CLK period so the
  // first bit has a full period of setup, giving 43 half-periods per frame.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= 5'd0;
      shreg_q   <= '0;
      ph_q      <= 1'b0;
      lead_q    <= 1'b0;
      tx_clk_q  <= 1'b0;
      tx_data_q <= 1'b0;
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      div_q <= (state_q == ST_IDLE || tick_s) ? '0 : div_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          tx_clk_q  <= 1'b0;
          tx_load_q <= 1'b0;
          if (pop_s) begin
            shreg_q   <= frame_d[SPI_FRAME_W-2:0];
            tx_data_q <= frame_d[SPI_FRAME_W-1];
            bit_cnt_q <= 5'd0;
            ph_q      <= 1'b0;
            lead_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: if (tick_s) begin
          ph_q <= ~ph_q;
          if (!ph_q) begin
            tx_clk_q <= ~lead_q;
          end else begin
            tx_clk_q <= 1'b0;
            if (lead_q) begin
              lead_q <= 1'b0;
            end else if (bit_cnt_q == 5'd18) begin
              tx_load_q <= 1'b1;
              state_q   <= ST_LOAD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              tx_data_q <= shreg_q[SPI_FRAME_W-2];
              shreg_q   <= {shreg_q[SPI_FRAME_W-3:0], 1'b0};
            end
          end
        end
        ST_LOAD: if (tick_s) begin
          ph_q <= ~ph_q;
          if (!ph_q) begin
            tx_clk_q <= 1'b1;
          end else begin
            tx_clk_q  <= 1'b0;
            tx_load_q <= 1'b0;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: if (tick_s) begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TX_CLK  = tx_clk_q;
  assign TX_DATA = tx_data_q;
  assign TX_LOAD = tx_load_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_output_process_spi.sv
// Self-checking bench: a frame monitor compares every serialised frame against
// a queue of expected {ADDR, word} frames and checks frame duration.
module tb_output_process_spi;

  localparam int DEPTH   = 256;
  localparam int DIV     = 4;
  localparam logic [2:0] A = 3'd1;
  localparam int FRAME_CYC = 43 * DIV;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WR_REQ = 1'b0;
  logic [15:0] DATA = 16'd0;
  logic        FULL;
  logic [8:0]  USED;
  logic        OVF;
  logic        RX_STOP = 1'b0;
  logic        TX_CLK, TX_DATA, TX_LOAD, BUSY;

  output_process_spi #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV), .ADDR(A)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .WR_REQ(WR_REQ), .DATA(DATA),
    .FULL(FULL), .USED(USED), .OVF(OVF), .RX_STOP(RX_STOP),
    .TX_CLK(TX_CLK), .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .BUSY(BUSY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frames_done = 0;
  int rise_cnt = 0;
  int last_start = 0;
  bit load_seen = 1'b0;
  logic [18:0] exp_q[$];
  int start_q[$];

  logic [18:0] mon_bits = '0;
  int mon_n = 0;
  logic prev_clk = 1'b0, prev_load = 1'b0, prev_busy = 1'b0;

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // Frame monitor: collects bits on TX_CLK rises outside TX_LOAD.
  always @(negedge SYS_CLK) begin
    logic [18:0] e;
    if (!RST) begin
      mon_n = 0; prev_clk = 1'b0; prev_load = 1'b0; prev_busy = 1'b0;
    end else begin
      if (TX_CLK && !prev_clk && !TX_LOAD) begin
        mon_bits = {mon_bits[17:0], TX_DATA};
        mon_n++;
        rise_cnt++;
      end
      if (TX_LOAD) load_seen = 1'b1;
      if (!TX_LOAD && prev_load) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_unexpected: got %h (%0d bits), required none", mon_bits, mon_n);
        end else begin
          e = exp_q.pop_front();
          if (mon_n !== 19 || mon_bits !== e) begin
            n_err++;
            $display("FAIL frame_content: got %h (%0d bits), required %h (19 bits)", mon_bits, mon_n, e);
          end
        end
        mon_n = 0;
        frames_done++;
      end
      if (BUSY && !prev_busy) begin
        start_q.push_back(cyc);
        last_start = cyc;
        rise_cnt = 0;
      end
      if (!BUSY && prev_busy) begin
        n_cmp++;
        if (cyc - last_start !== FRAME_CYC) begin
          n_err++;
          $display("FAIL busy_length: got %0d cycles, required %0d", cyc - last_start, FRAME_CYC);
        end
      end
      prev_clk = TX_CLK; prev_load = TX_LOAD; prev_busy = BUSY;
    end
  end

  task automatic write_word(input logic [15:0] w);
    @(negedge SYS_CLK);
    WR_REQ = 1'b1; DATA = w;
    @(negedge SYS_CLK);
    WR_REQ = 1'b0; DATA = 16'($urandom);
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge SYS_CLK);
      k++;
    end
    n_cmp++;
    if (frames_done < target) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d frames, required %0d", nm, frames_done, target);
    end
    repeat (2 * DIV + 2) @(negedge SYS_CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    RST = 1'b1;
    @(negedge SYS_CLK);
    n_cmp++;
    if ({FULL, USED, OVF, TX_CLK, TX_DATA, TX_LOAD, BUSY} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: got FULL=%b USED=%0d OVF=%b CLK=%b DATA=%b LOAD=%b BUSY=%b, required all 0",
               FULL, USED, OVF, TX_CLK, TX_DATA, TX_LOAD, BUSY);
    end
  endtask

  task automatic test_single();
    int base = frames_done;
    logic [15:0] w = 16'hA5C3;
    exp_q.push_back({A, w});
    @(negedge SYS_CLK);
    WR_REQ = 1'b1; DATA = w;
    @(negedge SYS_CLK);
    WR_REQ = 1'b0;
    n_cmp++;
    if (USED !== 9'd1 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL single_used_n1: got USED=%0d BUSY=%b, required USED=1 BUSY=0", USED, BUSY);
    end
    @(negedge SYS_CLK);
    n_cmp++;
    if (USED !== 9'd0 || BUSY !== 1'b1 || TX_DATA !== A[2]) begin
      n_err++;
      $display("FAIL single_start_n2: got USED=%0d BUSY=%b TX_DATA=%b, required 0 1 %b", USED, BUSY, TX_DATA, A[2]);
    end
    wait_frames(base + 1, 3 * FRAME_CYC, "single");
  endtask

  task automatic test_back_to_back();
    int base = frames_done;
    logic [8:0] exp_used[3] = '{9'd1, 9'd1, 9'd2};
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] w = 16'($urandom);
      exp_q.push_back({A, w});
      @(negedge SYS_CLK);
      if (i > 0) begin
        n_cmp++;
        if (USED !== exp_used[i-1]) begin
          n_err++;
          $display("FAIL b2b_used_%0d: got %0d, required %0d", i - 1, USED, exp_used[i-1]);
        end
      end
      WR_REQ = 1'b1; DATA = w;
    end
    @(negedge SYS_CLK);
    WR_REQ = 1'b0;
    n_cmp++;
    if (USED !== exp_used[2]) begin
      n_err++;
      $display("FAIL b2b_used_2: got %0d, required %0d", USED, exp_used[2]);
    end
    wait_frames(base + 3, 5 * FRAME_CYC, "b2b");
    n_cmp++;
    if (start_q.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_starts: got %0d frame starts, required 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (start_q[i] - start_q[i-1] !== FRAME_CYC + 1) begin
          n_err++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles, required %0d", i, start_q[i] - start_q[i-1], FRAME_CYC + 1);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int base = frames_done;
    RX_STOP = 1'b1;
    repeat (4) @(negedge SYS_CLK);
    for (int i = 0; i < DEPTH + 2; i++) begin
      logic [15:0] w = 16'($urandom);
      if (i < DEPTH) exp_q.push_back({A, w});
      WR_REQ = 1'b1; DATA = w;
      @(negedge SYS_CLK);
    end
    WR_REQ = 1'b0;
    @(negedge SYS_CLK);
    n_cmp++;
    if (FULL !== 1'b1 || USED !== 9'd256 || OVF !== 1'b1 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_state: got FULL=%b USED=%0d OVF=%b BUSY=%b, required 1 256 1 0", FULL, USED, OVF, BUSY);
    end
    RX_STOP = 1'b0;
    wait_frames(base + DEPTH, DEPTH * (FRAME_CYC + 1) + 50, "ovf");
    repeat (2 * FRAME_CYC) @(negedge SYS_CLK);
    n_cmp++;
    if (frames_done - base !== DEPTH || USED !== 9'd0 || FULL !== 1'b0 || OVF !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: got frames=%0d USED=%0d FULL=%b OVF=%b, required %0d 0 0 1",
               frames_done - base, USED, FULL, OVF, DEPTH);
    end
  endtask

  task automatic test_stop_mid();
    int base = frames_done;
    int k = 0;
    int rel;
    start_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back({A, 16'($urandom)});
    @(negedge SYS_CLK);
    WR_REQ = 1'b1; DATA = exp_q[0][15:0];
    @(negedge SYS_CLK);
    DATA = exp_q[1][15:0];
    @(negedge SYS_CLK);
    WR_REQ = 1'b0;
    while (!(BUSY && rise_cnt >= 5) && k < 2 * FRAME_CYC) begin
      @(negedge SYS_CLK);
      k++;
    end
    RX_STOP = 1'b1;
    wait_frames(base + 1, 2 * FRAME_CYC, "stop_f1");
    repeat (300) @(negedge SYS_CLK);
    n_cmp++;
    if (BUSY !== 1'b0 || USED !== 9'd1 || frames_done - base !== 1) begin
      n_err++;
      $display("FAIL stop_hold: got BUSY=%b USED=%0d frames=%0d, required 0 1 1", BUSY, USED, frames_done - base);
    end
    RX_STOP = 1'b0;
    rel = cyc;
    wait_frames(base + 2, 3 * FRAME_CYC, "stop_f2");
    n_cmp++;
    if (start_q.size() !== 2 || start_q[1] - rel < 2) begin
      n_err++;
      $display("FAIL stop_release: got %0d starts, last at +%0d cycles, required 2 starts at >= +2",
               start_q.size(), (start_q.size() > 0) ? start_q[start_q.size()-1] - rel : -1);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int base = frames_done;
    load_seen = 1'b0;
    exp_q.push_back({A, 16'($urandom)});
    write_word(exp_q[exp_q.size()-1][15:0]);
    write_word(16'($urandom));
    while (!(BUSY && rise_cnt >= 10) && k < 2 * FRAME_CYC) begin
      @(negedge SYS_CLK);
      k++;
    end
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({TX_CLK, TX_DATA, TX_LOAD, BUSY} !== 4'd0 || USED !== 9'd0 || OVF !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: got CLK=%b DATA=%b LOAD=%b BUSY=%b USED=%0d OVF=%b, required all 0",
               TX_CLK, TX_DATA, TX_LOAD, BUSY, USED, OVF);
    end
    exp_q.delete();
    repeat (3) @(negedge SYS_CLK);
    RST = 1'b1;
    repeat (2 * FRAME_CYC) @(negedge SYS_CLK);
    n_cmp++;
    if (load_seen !== 1'b0 || BUSY !== 1'b0 || frames_done !== base) begin
      n_err++;
      $display("FAIL rst_mid_after: got load_seen=%b BUSY=%b frames=%0d, required 0 0 %0d", load_seen, BUSY, frames_done, base);
    end
  endtask

  task automatic test_random();
    int base = frames_done;
    int n = 6;
    for (int i = 0; i < n; i++) begin
      logic [15:0] w = 16'($urandom);
      exp_q.push_back({A, w});
      write_word(w);
      repeat ($urandom_range(0, 250)) @(negedge SYS_CLK);
    end
    wait_frames(base + n, (n + 1) * (FRAME_CYC + 1), "random");
    n_cmp++;
    if (exp_q.size() !== 0 || USED !== 9'd0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got pending=%0d USED=%0d BUSY=%b, required 0 0 0", exp_q.size(), USED, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_stop_mid();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
